// File: rtl/fnd_arb_pkg.sv
// fnd_arb_pkg: shared state type, default ms timing constants and index helpers for the FND arbiter
package fnd_arb_pkg;

    typedef enum logic {NORMAL, OVERRIDE} arb_state_e;

    localparam int DEF_TICK_DIV  = 100_000;
    localparam int DEF_HOLD_MS   = 2000;
    localparam int DEF_SCROLL_MS = 3000;
    localparam int DEF_BLINK_MS  = 500;

    // First valid index scanning x+1, x+2, ... wrapping, ending with x itself; x when none valid.
    // Scanning from the far end lets the nearest valid index overwrite the result last.
    function automatic logic [2:0] next_valid(input logic [2:0] x, input logic [7:0] v, input int n);
        logic [2:0] r;
        int idx;
        r = x;
        for (int i = 8; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(x) + i) % n;
                if (v[3'(idx)]) r = 3'(idx);
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler emitting a 1-cycle tick every TICK_DIV clocks
//   clk     in  system clock
//   reset_p in  async active-high reset
//   tick    out high for one cycle when the prescaler wraps
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == CW'(TICK_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: shares one 4-digit FND driver among NUM_SRC sources with scroll, override and blink
//   clk, reset_p             clock, async active-high reset
//   src_value/valid/urgent   per-source 16-bit value, valid flag, 1-cycle override request
//   src_blink                per-source 4-bit digit blink mask ([3] = leftmost)
//   mode_btn, auto_scroll    next source / cancel override pulse, timed scroll enable
//   disp_value, digit_blank  registered value and dark-digit mask for the driver
//   grant, hold_active       one-hot shown source (0 = none), override in progress
module fnd_display_arbiter
    import fnd_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int HOLD_MS   = DEF_HOLD_MS,
    parameter int SCROLL_MS = DEF_SCROLL_MS,
    parameter int BLINK_MS  = DEF_BLINK_MS
) (
    input  logic                    clk,
    input  logic                    reset_p,
    input  logic [16*NUM_SRC-1:0]   src_value,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0]      src_urgent,
    input  logic [4*NUM_SRC-1:0]    src_blink,
    input  logic                    mode_btn,
    input  logic                    auto_scroll,
    output logic [15:0]             disp_value,
    output logic [3:0]              digit_blank,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    hold_active
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int SW = $clog2(SCROLL_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      sel_q, sel_d, ovr_q, ovr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      scroll_q, scroll_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               phase_q, phase_d;
    logic [15:0]        disp_q, disp_d;
    logic [3:0]         blank_q, blank_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               hold_out_q, hold_out_d;
    logic [NUM_SRC-1:0] urg;
    logic [IW-1:0]      urg_idx, nxt, g_cur, g_nxt;
    logic               tick;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ovr_d    = ovr_q;
        hold_d   = hold_q;
        scroll_d = scroll_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        urg      = src_urgent & src_valid;
        urg_idx  = IW'(lowest_set(8'(urg)));
        nxt      = IW'(next_valid(3'(sel_q), 8'(src_valid), NUM_SRC));
        if (state_q == NORMAL) begin
            if (|urg) begin
                state_d  = OVERRIDE;
                ovr_d    = urg_idx;
                hold_d   = HW'(HOLD_MS);
                scroll_d = '0;
            end else if (mode_btn || !src_valid[sel_q]) begin
                sel_d    = nxt;
                scroll_d = '0;
            end else if (!auto_scroll) begin
                scroll_d = '0;
            end else if (tick) begin
                sel_d    = (scroll_q == SW'(SCROLL_MS - 1)) ? nxt : sel_q;
                scroll_d = (scroll_q == SW'(SCROLL_MS - 1)) ? '0 : scroll_q + SW'(1);
            end
        end else begin
            // Only an urgent at or below the current override index counts; it also wins over expiry and the button.
            if (|urg && urg_idx <= ovr_q) begin
                ovr_d  = urg_idx;
                hold_d = HW'(HOLD_MS);
            end else if (mode_btn || !src_valid[ovr_q]) begin
                state_d = NORMAL;
                hold_d  = '0;
            end else if (tick) begin
                state_d = (hold_q <= HW'(1)) ? NORMAL : OVERRIDE;
                hold_d  = (hold_q <= HW'(1)) ? '0 : hold_q - HW'(1);
            end
        end
        g_cur = (state_q == OVERRIDE) ? ovr_q : sel_q;
        g_nxt = (state_d == OVERRIDE) ? ovr_d : sel_d;
        // A newly shown source restarts its blink cycle lit.
        if (g_nxt != g_cur) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            blink_d = (blink_q == BW'(BLINK_MS - 1)) ? '0 : blink_q + BW'(1);
            phase_d = (blink_q == BW'(BLINK_MS - 1)) ? ~phase_q : phase_q;
        end
        grant_d    = src_valid[g_cur] ? (NUM_SRC'(1) << g_cur) : '0;
        disp_d     = src_valid[g_cur] ? src_value[{g_cur, 4'b0} +: 16] : 16'h0;
        blank_d    = src_valid[g_cur] ? (src_blink[{g_cur, 2'b0} +: 4] & {4{phase_q}}) : 4'hF;
        hold_out_d = state_q == OVERRIDE;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= NORMAL;
            sel_q    <= '0;
            ovr_q    <= '0;
            hold_q   <= '0;
            scroll_q <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ovr_q    <= ovr_d;
            hold_q   <= hold_d;
            scroll_q <= scroll_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            disp_q     <= 16'h0;
            blank_q    <= 4'hF;
            grant_q    <= '0;
            hold_out_q <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            blank_q    <= blank_d;
            grant_q    <= grant_d;
            hold_out_q <= hold_out_d;
        end
    end

    assign disp_value  = disp_q;
    assign digit_blank = blank_q;
    assign grant       = grant_q;
    assign hold_active = hold_out_q;
endmodule

// File: tb/tb_fnd_display_arbiter.sv
// tb_fnd_display_arbiter: directed scoreboard bench for fnd_display_arbiter with scaled timing
module tb_fnd_display_arbiter;
    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [63:0] src_value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [3:0]  src_valid = 4'b0101;
    logic [3:0]  src_urgent = '0;
    logic [15:0] src_blink = '0;
    logic        mode_btn = 1'b0;
    logic        auto_scroll = 1'b0;
    logic [15:0] disp_value;
    logic [3:0]  digit_blank;
    logic [3:0]  grant;
    logic        hold_active;

    typedef struct packed {
        logic [3:0]  grant;
        logic [15:0] disp;
        logic [3:0]  blank;
        logic        hold;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n;

    fnd_display_arbiter #(
        .NUM_SRC(4), .TICK_DIV(10), .HOLD_MS(5), .SCROLL_MS(8), .BLINK_MS(3)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .src_value   (src_value),
        .src_valid   (src_valid),
        .src_urgent  (src_urgent),
        .src_blink   (src_blink),
        .mode_btn    (mode_btn),
        .auto_scroll (auto_scroll),
        .disp_value  (disp_value),
        .digit_blank (digit_blank),
        .grant       (grant),
        .hold_active (hold_active)
    );

    always #5 clk = ~clk;

    task automatic expect_o(input logic [3:0] g, input logic [3:0] b, input logic h);
        obs_t e;
        e.grant = g;
        e.blank = b;
        e.hold  = h;
        e.disp  = 16'h0;
        for (int i = 0; i < 4; i++) if (g[i]) e.disp = 16'h1111 * 16'(i + 1);
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        obs_t e, o;
        o = {grant, disp_value, digit_blank, hold_active};
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got grant=%b disp=%h blank=%b hold=%b, want grant=%b disp=%h blank=%b hold=%b",
                   tag, o.grant, o.disp, o.blank, o.hold, e.grant, e.disp, e.blank, e.hold);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] urg, input logic btn);
        @(negedge clk);
        src_urgent = urg;
        mode_btn   = btn;
        @(negedge clk);
        src_urgent = '0;
        mode_btn   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_sig(input string tag, input bit on_blank, input logic [3:0] v, input int budget, output int cnt);
        cnt = 0;
        while (((on_blank ? digit_blank : grant) !== v) && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        assert ((on_blank ? digit_blank : grant) === v) else begin
            errors++;
            $error("FAIL %s: timeout after %0d cycles, got %b want %b", tag, cnt, on_blank ? digit_blank : grant, v);
        end
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d cycles, want %0d..%0d", tag, v, lo, hi);
        end
    endtask

    initial begin
        // 1. reset state and button stepping over valid sources 0 and 2
        cyc(3);
        expect_o(4'b0000, 4'hF, 1'b0); check("reset");
        reset_p = 1'b0;
        @(negedge clk);
        expect_o(4'b0001, 4'h0, 1'b0); check("first_src");
        pulse(4'b0000, 1'b1);
        expect_o(4'b0100, 4'h0, 1'b0); check("btn_to_2");
        pulse(4'b0000, 1'b1);
        expect_o(4'b0001, 4'h0, 1'b0); check("btn_wrap_0");

        // 2. auto-scroll over all four sources, button mid-period restarts the timer
        src_valid   = 4'b1111;
        auto_scroll = 1'b1;
        wait_sig("scroll_1", 1'b0, 4'b0010, 100, n);
        expect_o(4'b0010, 4'h0, 1'b0); check("scroll_val_1");
        wait_sig("scroll_2", 1'b0, 4'b0100, 100, n);
        check_range("scroll_period_2", n, 80, 80);
        wait_sig("scroll_3", 1'b0, 4'b1000, 100, n);
        check_range("scroll_period_3", n, 80, 80);
        wait_sig("scroll_0", 1'b0, 4'b0001, 100, n);
        check_range("scroll_period_0", n, 80, 80);
        expect_o(4'b0001, 4'h0, 1'b0); check("scroll_val_0");
        cyc(39);
        pulse(4'b0000, 1'b1);
        expect_o(4'b0010, 4'h0, 1'b0); check("btn_mid_scroll");
        wait_sig("scroll_after_btn", 1'b0, 4'b0100, 100, n);
        check_range("scroll_restart", n, 71, 80);
        auto_scroll = 1'b0;
        pulse(4'b0000, 1'b1);
        expect_o(4'b1000, 4'h0, 1'b0); check("btn_to_3");
        pulse(4'b0000, 1'b1);
        expect_o(4'b0001, 4'h0, 1'b0); check("btn_back_0");

        // 3. override of source 2 for the hold time
        pulse(4'b0100, 1'b0);
        expect_o(4'b0100, 4'h0, 1'b1); check("ovr_2");
        wait_sig("hold_expire", 1'b0, 4'b0001, 70, n);
        check_range("hold_len", n, 41, 50);
        expect_o(4'b0001, 4'h0, 1'b0); check("after_hold");

        // 4. priority inside override, reload, button cancel
        pulse(4'b0100, 1'b0);
        expect_o(4'b0100, 4'h0, 1'b1); check("ovr_2_again");
        cyc(1);
        pulse(4'b1000, 1'b0);
        expect_o(4'b0100, 4'h0, 1'b1); check("ovr_higher_ignored");
        cyc(20);
        pulse(4'b0010, 1'b0);
        expect_o(4'b0010, 4'h0, 1'b1); check("ovr_preempt_1");
        cyc(35);
        expect_o(4'b0010, 4'h0, 1'b1); check("ovr_reloaded");
        pulse(4'b0000, 1'b1);
        expect_o(4'b0001, 4'h0, 1'b0); check("btn_cancel");

        // 5. urgent beats button; urgent from invalid source ignored
        pulse(4'b0010, 1'b1);
        expect_o(4'b0010, 4'h0, 1'b1); check("urg_beats_btn");
        pulse(4'b0000, 1'b1);
        expect_o(4'b0001, 4'h0, 1'b0); check("sel_not_advanced");
        src_valid = 4'b0111;
        pulse(4'b1000, 1'b0);
        expect_o(4'b0001, 4'h0, 1'b0); check("urg_invalid_ignored");
        src_valid = 4'b1111;

        // 6. blink, no valid source, reset during override
        src_blink[3:0] = 4'b1001;
        wait_sig("blink_on", 1'b1, 4'b1001, 70, n);
        expect_o(4'b0001, 4'b1001, 1'b0); check("blink_dark");
        wait_sig("blink_lit", 1'b1, 4'b0000, 40, n);
        check_range("blink_half_1", n, 30, 30);
        wait_sig("blink_dark2", 1'b1, 4'b1001, 40, n);
        check_range("blink_half_2", n, 30, 30);
        @(negedge clk);
        src_valid = 4'b0000;
        cyc(2);
        expect_o(4'b0000, 4'hF, 1'b0); check("none_valid");
        src_valid = 4'b1111;
        cyc(2);
        pulse(4'b0100, 1'b0);
        expect_o(4'b0100, 4'h0, 1'b1); check("ovr_before_reset");
        reset_p = 1'b1;
        #1;
        expect_o(4'b0000, 4'hF, 1'b0); check("async_reset");
        cyc(3);
        expect_o(4'b0000, 4'hF, 1'b0); check("reset_held");
        reset_p = 1'b0;
        cyc(2);
        expect_o(4'b0001, 4'h0, 1'b0); check("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
